down_counter: RTL and testbench

DOWN_COUNTER -- requirements
Module: down_counter

---
 rtl/down_counter_if.sv | 25 ++
 rtl/down_counter.sv | 60 ++++++
 tb/tb_down_counter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/down_counter_if.sv
// Control and status bundle for down_counter: load/enable controls in,
// registered count and FSM status out.
interface down_counter_if #(
  parameter int WIDTH = 4
) ();
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             underflow;
  logic             busy;
  logic             done;

  modport master (
    output load, load_val, en, auto_reload,
    input  out, tc, underflow, busy, done
  );

  modport slave (
    input  load, load_val, en, auto_reload,
    output out, tc, underflow, busy, done
  );
endinterface

// File: rtl/down_counter.sv
// Loadable down counter with IDLE/RUN/DONE control, optional auto-reload
// at underflow and a one-cycle registered underflow pulse.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  down_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic             unf, unf_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      reload <= '0;
      unf    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      reload <= reload_n;
      unf    <= unf_n;
    end
  end

  // Load wins over counting; the count never wraps below zero, it either
  // reloads or parks at 0 in DONE.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    reload_n = reload;
    unf_n    = 1'b0;
    if (bus.load) begin
      cnt_n    = bus.load_val;
      reload_n = bus.load_val;
      state_n  = (bus.load_val != '0) ? RUN : IDLE;
    end else if (state == RUN && bus.en) begin
      if (cnt != '0) begin
        cnt_n = cnt - 1'b1;
      end else begin
        unf_n = 1'b1;
        if (bus.auto_reload) cnt_n   = reload;
        else                 state_n = DONE;
      end
    end
  end

  assign bus.out       = cnt;
  assign bus.tc        = (cnt == '0);
  assign bus.underflow = unf;
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: the driver queues the expected status
// for every cycle it drives, the monitor checks it after each rising edge.
module tb_down_counter;
  localparam int WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             unf;
    logic             busy;
    logic             done;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  down_counter_if #(.WIDTH(WIDTH)) bus ();

  down_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic exp_t sample();
    exp_t a;
    a.out  = bus.out;
    a.tc   = bus.tc;
    a.unf  = bus.underflow;
    a.busy = bus.busy;
    a.done = bus.done;
    return a;
  endfunction

  task automatic check(input string name, input exp_t exp);
    exp_t act;
    act = sample();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got out=%0d tc=%0b unf=%0b busy=%0b done=%0b, want out=%0d tc=%0b unf=%0b busy=%0b done=%0b",
               name, act.out, act.tc, act.unf, act.busy, act.done,
               exp.out, exp.tc, exp.unf, exp.busy, exp.done);
    end
  endtask

  // Drive one cycle of inputs and queue the status expected after the edge.
  task automatic step(input logic ld, input logic [WIDTH-1:0] val, input logic e,
                      input logic ar, input logic [WIDTH-1:0] eo, input logic eu,
                      input logic eb, input logic ed);
    exp_t x;
    @(negedge clk);
    bus.load        = ld;
    bus.load_val    = val;
    bus.en          = e;
    bus.auto_reload = ar;
    x.out  = eo;
    x.tc   = (eo == '0);
    x.unf  = eu;
    x.busy = eb;
    x.done = ed;
    sb.push_back(x);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries still pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check("cycle", x);
      end
    end
  end

  initial begin : driver
    exp_t rst_exp;
    rst_exp = '{out: '0, tc: 1'b1, unf: 1'b0, busy: 1'b0, done: 1'b0};
    bus.load = 0; bus.load_val = '0; bus.en = 0; bus.auto_reload = 0;
    reset = 1'b0;
    #2;
    check("reset_state", rst_exp);
    @(negedge clk);
    reset = 1'b1;

    // idle after reset: en ignored
    step(0, 0, 1, 0, 0, 0, 0, 0);

    // scenario 1: count 3..0, then underflow into DONE
    step(1, 3, 1, 0, 3, 0, 1, 0);
    step(0, 0, 1, 0, 2, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0, 1);

    // scenario 2: auto-reload, period 4, load at 0 suppresses underflow
    step(1, 3, 1, 1, 3, 0, 1, 0);
    step(0, 0, 1, 1, 2, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0, 1, 0);
    step(0, 0, 1, 1, 0, 0, 1, 0);
    step(0, 0, 1, 1, 3, 1, 1, 0);
    step(0, 0, 1, 1, 2, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0, 1, 0);
    step(0, 0, 1, 1, 0, 0, 1, 0);
    step(1, 2, 1, 1, 2, 0, 1, 0);

    // scenario 3: en 1,0,0,1
    step(1, 5, 0, 0, 5, 0, 1, 0);
    step(0, 0, 1, 0, 4, 0, 1, 0);
    step(0, 0, 0, 0, 4, 0, 1, 0);
    step(0, 0, 0, 0, 4, 0, 1, 0);
    step(0, 0, 1, 0, 3, 0, 1, 0);

    // scenario 4: load beats en at out=2
    step(0, 0, 1, 0, 2, 0, 1, 0);
    step(1, 9, 1, 0, 9, 0, 1, 0);
    step(0, 0, 1, 0, 8, 0, 1, 0);

    // scenario 5: load 0 stays IDLE, en ignored, no underflow
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);

    // scenario 6: async reset mid-count at out=6
    step(1, 7, 0, 0, 7, 0, 1, 0);
    step(0, 0, 1, 0, 6, 0, 1, 0);
    drain();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", rst_exp);
    #1;
    reset = 1'b1;
    step(0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
